// File: rtl/mm2s_rd_engine.sv
// mm2s_rd_engine
//   Upstream stage of the MM2S path. Accepts one transfer command (start
//   address, beat count), splits it into AXI4 INCR read bursts that never
//   exceed MAX_BURST beats or cross a 4 KB boundary, and keeps at most
//   MAX_OUTST bursts in flight. Returned read data is passed straight into
//   the downstream FIFO. The final beat of the transfer is tagged with
//   fifo_wlast.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/ready/addr/beats  transfer command (accepted only in IDLE)
//   m_axi_ar*                AXI4 read address channel (master side)
//   m_axi_r*                 AXI4 read data channel (master side)
//   fifo_full                FIFO back-pressure
//   fifo_wr_en/wdata/wlast   FIFO write port (combinational from R)
//   busy                     command in progress
//   done                     one-cycle completion pulse
//   err                      sticky error status of the last command
module mm2s_rd_engine #(
    parameter int AW        = 32,
    parameter int DW        = 64,
    parameter int LEN_W     = 16,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_beats,
    output logic [AW-1:0]    m_axi_araddr,
    output logic [7:0]       m_axi_arlen,
    output logic [2:0]       m_axi_arsize,
    output logic [1:0]       m_axi_arburst,
    output logic             m_axi_arvalid,
    input  logic             m_axi_arready,
    input  logic [DW-1:0]    m_axi_rdata,
    input  logic [1:0]       m_axi_rresp,
    input  logic             m_axi_rlast,
    input  logic             m_axi_rvalid,
    output logic             m_axi_rready,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [DW-1:0]    fifo_wdata,
    output logic             fifo_wlast,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BPB = DW / 8;
    localparam int BSH = $clog2(BPB);
    localparam int PW  = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int OW  = $clog2(MAX_OUTST + 1);
    localparam int CW  = (LEN_W > 13) ? LEN_W : 13;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              init_q, init_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]  ar_rem_q, ar_rem_d;
    logic [LEN_W-1:0]  rx_rem_q, rx_rem_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [8:0]        blq_q [MAX_OUTST];
    logic [8:0]        blq_d [MAX_OUTST];
    logic              err_flag_q, err_flag_d;
    logic              err_q, err_d;

    logic              accept, ar_hs, r_hs, pop;
    logic [CW-1:0]     bnd_beats, min_c;
    logic [8:0]        blen;
    logic [8:0]        head;
    logic              head_eob;
    logic [AW-1:0]     ar_step;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUTST - 1)) return '0;
        return p + 1'b1;
    endfunction

    // Burst length: remaining beats, clipped to MAX_BURST and to the beats
    // left before the next 4 KB boundary.
    always_comb begin
        bnd_beats = CW'((13'd4096 - {1'b0, addr_q[11:0]}) >> BSH);
        min_c     = CW'(ar_rem_q);
        if (min_c > CW'(MAX_BURST)) min_c = CW'(MAX_BURST);
        if (min_c > bnd_beats)      min_c = bnd_beats;
    end

    assign blen     = 9'(min_c);
    assign ar_step  = AW'(blen) << BSH;
    assign head     = blq_q[rptr_q];
    assign head_eob = (head == 9'd1);

    assign cmd_ready     = init_q && (state_q == S_IDLE);
    assign accept        = cmd_valid && cmd_ready;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;

    assign m_axi_arvalid = (state_q == S_ISSUE) && (outst_q < OW'(MAX_OUTST));
    assign m_axi_araddr  = addr_q;
    // Outside ISSUE ar_rem is 0 and blen collapses to 0; keep arlen at 0 then.
    assign m_axi_arlen   = (blen == 9'd0) ? 8'd0 : 8'(blen - 9'd1);
    assign m_axi_arsize  = 3'(BSH);
    assign m_axi_arburst = 2'b01;
    assign ar_hs         = m_axi_arvalid && m_axi_arready;

    assign m_axi_rready  = busy && !fifo_full;
    assign r_hs          = m_axi_rvalid && m_axi_rready;
    assign fifo_wr_en    = r_hs;
    assign fifo_wdata    = r_hs ? m_axi_rdata : '0;
    assign fifo_wlast    = r_hs && (rx_rem_q == LEN_W'(1));
    assign pop           = r_hs && (outst_q != '0) && head_eob;

    always_comb begin
        state_d    = state_q;
        init_d     = 1'b1;
        addr_d     = addr_q;
        ar_rem_d   = ar_rem_q;
        rx_rem_d   = rx_rem_q;
        outst_d    = outst_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        blq_d      = blq_q;
        err_flag_d = err_flag_q;
        err_d      = err_q;

        // Expected-beat queue: pushed in AR issue order, head counts down.
        if (ar_hs) begin
            blq_d[wptr_q] = blen;
            wptr_d        = ptr_inc(wptr_q);
        end

        if (r_hs) begin
            if (rx_rem_q != '0) rx_rem_d = rx_rem_q - 1'b1;
            if (m_axi_rresp != 2'b00) err_flag_d = 1'b1;
            if (outst_q == '0) begin
                // Data with no burst outstanding cannot be accounted for.
                err_flag_d = 1'b1;
            end else begin
                if (m_axi_rlast != head_eob) err_flag_d = 1'b1;
                if (head_eob) rptr_d = ptr_inc(rptr_q);
                else          blq_d[rptr_q] = head - 9'd1;
            end
        end

        if (ar_hs && !pop)      outst_d = outst_q + 1'b1;
        else if (!ar_hs && pop) outst_d = outst_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d     = cmd_addr & ~AW'(BPB - 1);
                    ar_rem_d   = cmd_beats;
                    rx_rem_d   = cmd_beats;
                    err_flag_d = 1'b0;
                    err_d      = 1'b0;
                    state_d    = (cmd_beats == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (ar_hs) begin
                    addr_d   = addr_q + ar_step;
                    ar_rem_d = ar_rem_q - LEN_W'(blen);
                    if (ar_rem_d == '0) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((rx_rem_q == '0) && (outst_q == '0)) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // err is published on entry to DONE and held until the next accept.
        if ((state_d == S_DONE) && (state_q != S_DONE)) err_d = err_flag_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b0;
            addr_q     <= '0;
            ar_rem_q   <= '0;
            rx_rem_q   <= '0;
            outst_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            err_flag_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) blq_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            addr_q     <= addr_d;
            ar_rem_q   <= ar_rem_d;
            rx_rem_q   <= rx_rem_d;
            outst_q    <= outst_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            err_flag_q <= err_flag_d;
            err_q      <= err_d;
            blq_q      <= blq_d;
        end
    end

endmodule
